// File: rtl/flit_to_axis_rx.sv
// rtl/flit_to_axis_rx.sv - credit-based flit link receiver reassembling flits into AXI-Stream beats
module flit_to_axis_rx #(
   parameter int DEST_WIDTH           = 6,
   parameter int FLIT_WIDTH           = 128,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int FLIT_BUFFER_DEPTH    = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [FLIT_WIDTH-1:0]                      data_in,
   input  logic [DEST_WIDTH-1:0]                      dest_in,
   input  logic                                       is_tail_in,
   input  logic                                       send_in,
   output logic                                       credit_out,
   output logic                                       axis_tvalid,
   input  logic                                       axis_tready,
   output logic [FLIT_WIDTH*SERIALIZATION_FACTOR-1:0] axis_tdata,
   output logic                                       axis_tlast,
   output logic [DEST_WIDTH-1:0]                      axis_tdest,
   output logic                                       overflow_err,
   output logic                                       tail_err
);

   localparam int TW = FLIT_WIDTH * SERIALIZATION_FACTOR;
   localparam int AW = $clog2(FLIT_BUFFER_DEPTH);
   localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(SERIALIZATION_FACTOR - 1);

   logic [EW-1:0]         mem [FLIT_BUFFER_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr, fill;
   logic                  empty, full, wr_en, pop;
   logic [FLIT_WIDTH-1:0] head_data;
   logic [DEST_WIDTH-1:0] head_dest;
   logic                  head_tail;

   logic [IW-1:0]         idx;
   logic [TW-1:0]         asm_data, nxt_data;
   logic [DEST_WIDTH-1:0] asm_dest, nxt_dest;
   logic                  asm_tlast, asm_full, asm_full_n;
   logic                  out_free, move, last, beat_done, direct;

   // Depth is a power of two, so the fill count's MSB alone marks full.
   assign fill  = wr_ptr - rd_ptr;
   assign full  = fill[AW];
   assign empty = (fill == '0);
   assign {head_tail, head_dest, head_data} = mem[rd_ptr[AW-1:0]];

   assign out_free  = !axis_tvalid || axis_tready;
   assign move      = asm_full && out_free;
   assign pop       = !empty && (!asm_full || out_free);
   assign wr_en     = send_in && (!full || pop);
   assign last      = (idx == LAST_IDX);
   assign beat_done = pop && last;
   // A finishing beat skips the assembler when the output register can take it now.
   assign direct    = beat_done && !asm_full && out_free;
   assign asm_full_n = asm_full ? (move ? beat_done : 1'b1) : (beat_done && !out_free);

   always_comb begin
      nxt_data = asm_data;
      for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
         if (idx == IW'(k)) nxt_data[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
      end
      nxt_dest = (idx == '0) ? head_dest : asm_dest;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {is_tail_in, dest_in, data_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         idx          <= '0;
         asm_data     <= '0;
         asm_dest     <= '0;
         asm_tlast    <= 1'b0;
         asm_full     <= 1'b0;
         credit_out   <= 1'b0;
         axis_tvalid  <= 1'b0;
         axis_tdata   <= '0;
         axis_tlast   <= 1'b0;
         axis_tdest   <= '0;
         overflow_err <= 1'b0;
         tail_err     <= 1'b0;
      end else begin
         credit_out <= pop;
         asm_full   <= asm_full_n;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (send_in && full && !pop) overflow_err <= 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            asm_data <= nxt_data;
            asm_dest <= nxt_dest;
            idx      <= last ? '0 : idx + 1'b1;
            if (last) asm_tlast <= head_tail;
            if (head_tail && !last) tail_err <= 1'b1;
         end
         if (move) begin
            axis_tvalid <= 1'b1;
            axis_tdata  <= asm_data;
            axis_tlast  <= asm_tlast;
            axis_tdest  <= asm_dest;
         end else if (direct) begin
            axis_tvalid <= 1'b1;
            axis_tdata  <= nxt_data;
            axis_tlast  <= head_tail;
            axis_tdest  <= nxt_dest;
         end else if (axis_tready) begin
            axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flit_to_axis_rx.sv
// tb/tb_flit_to_axis_rx.sv - scoreboard bench for flit_to_axis_rx (SF=4 main instance, SF=1 instance)
module tb_flit_to_axis_rx;

   localparam int FW = 16;
   localparam int SF = 4;
   localparam int DW = 6;
   localparam int D  = 4;
   localparam int TW = FW * SF;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] data_in;
   logic [DW-1:0] dest_in;
   logic          is_tail_in, send_in, credit_out;
   logic          axis_tvalid, axis_tready, axis_tlast;
   logic [TW-1:0] axis_tdata;
   logic [DW-1:0] axis_tdest;
   logic          overflow_err, tail_err;

   logic [7:0]    data1;
   logic          send1, credit1, tvalid1, tlast1, ovf1, terr1;
   logic [7:0]    tdata1;
   logic [DW-1:0] tdest1;

   typedef struct packed {
      logic [TW-1:0] d;
      logic          l;
      logic [DW-1:0] dst;
   } beat_t;

   beat_t      q[$];
   logic [7:0] q1[$];
   beat_t      e;
   logic [7:0] e1;
   int n_chk = 0, n_fail = 0, credits = 0, cyc = 0;
   int v1_cnt = 0, v1_first = 0, v1_last = 0, c1_cnt = 0, c1_first = 0, c1_last = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flit_to_axis_rx #(.DEST_WIDTH(DW), .FLIT_WIDTH(FW), .SERIALIZATION_FACTOR(SF),
                     .FLIT_BUFFER_DEPTH(D)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
      .send_in(send_in), .credit_out(credit_out), .axis_tvalid(axis_tvalid),
      .axis_tready(axis_tready), .axis_tdata(axis_tdata), .axis_tlast(axis_tlast),
      .axis_tdest(axis_tdest), .overflow_err(overflow_err), .tail_err(tail_err));

   flit_to_axis_rx #(.DEST_WIDTH(DW), .FLIT_WIDTH(8), .SERIALIZATION_FACTOR(1),
                     .FLIT_BUFFER_DEPTH(D)) u_dut1 (
      .clk(clk), .rst(rst), .data_in(data1), .dest_in(6'h07), .is_tail_in(1'b1),
      .send_in(send1), .credit_out(credit1), .axis_tvalid(tvalid1), .axis_tready(1'b1),
      .axis_tdata(tdata1), .axis_tlast(tlast1), .axis_tdest(tdest1),
      .overflow_err(ovf1), .tail_err(terr1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a beat is handed over.
   always @(negedge clk) begin
      if (!rst) begin
         if (credit_out) credits++;
         if (axis_tvalid && axis_tready) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_beat: got %0h expected none", axis_tdata);
            end else begin
               e = q.pop_front();
               chk("beat_tdata", axis_tdata, e.d);
               chk("beat_tlast", axis_tlast, e.l);
               chk("beat_tdest", axis_tdest, e.dst);
            end
         end
         if (tvalid1) begin
            v1_cnt++;
            if (v1_cnt == 1) v1_first = cyc;
            v1_last = cyc;
            if (q1.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sf1_unexpected_beat: got %0h expected none", tdata1);
            end else begin
               e1 = q1.pop_front();
               chk("sf1_tdata", tdata1, e1);
               chk("sf1_tdest", tdest1, 6'h07);
            end
         end
         if (credit1) begin
            c1_cnt++;
            if (c1_cnt == 1) c1_first = cyc;
            c1_last = cyc;
         end
      end
   end

   task automatic send(input logic [FW-1:0] d, input logic [DW-1:0] ds, input logic tl);
      data_in = d; dest_in = ds; is_tail_in = tl; send_in = 1'b1;
      @(posedge clk); #1;
      send_in = 1'b0; is_tail_in = 1'b0;
   endtask

   task automatic push(input logic [TW-1:0] d, input logic l, input logic [DW-1:0] ds);
      beat_t b;
      b.d = d; b.l = l; b.dst = ds;
      q.push_back(b);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || axis_tvalid) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("drain_in_time", (n < 300), 1'b1);
   endtask

   // Credit-honoring transmitter: sends 3 beats' worth of flits without exceeding credits.
   task automatic fill(input logic [FW-1:0] base);
      int sent = 0, c0 = credits, n = 0;
      logic [DW-1:0] ds;
      while (sent < D + 2 * SF && n < 200) begin
         if (sent - (credits - c0) < D) begin
            ds = DW'(32'h20 + sent / SF);
            send(FW'(base + sent), ds, (sent % SF) == SF - 1);
            sent++;
         end else begin
            @(posedge clk); #1;
         end
         n++;
      end
      chk("fill_sent", sent, D + 2 * SF);
      for (int j = 0; j < 3; j++)
         push({FW'(base + 4*j + 3), FW'(base + 4*j + 2), FW'(base + 4*j + 1), FW'(base + 4*j)},
              1'b1, DW'(32'h20 + j));
   endtask

   initial begin
      int c0, s0;
      rst = 1'b1; data_in = '0; dest_in = '0; is_tail_in = 1'b0; send_in = 1'b0;
      axis_tready = 1'b1; data1 = '0; send1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", axis_tvalid, 0);
      chk("rst_tdata", axis_tdata, 0);
      chk("rst_tdest", axis_tdest, 0);
      chk("rst_tlast", axis_tlast, 0);
      chk("rst_credit", credit_out, 0);
      chk("rst_overflow", overflow_err, 0);
      chk("rst_tail_err", tail_err, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic beat with latency check on the final flit.
      c0 = credits;
      push(64'hA003_A002_A001_A000, 1'b1, 6'h15);
      send(16'hA000, 6'h15, 1'b0);
      send(16'hA001, 6'h15, 1'b0);
      send(16'hA002, 6'h15, 1'b0);
      send(16'hA003, 6'h15, 1'b1);
      chk("t1_tvalid_before", axis_tvalid, 0);
      @(posedge clk); #1;
      chk("t1_tvalid_latency", axis_tvalid, 1);
      drain();
      chk("t1_credits", credits - c0, 4);

      // Backpressure with credit-honoring transmitter.
      axis_tready = 1'b0;
      c0 = credits;
      fill(16'hB000);
      repeat (4) begin @(posedge clk); #1; end
      chk("t2_no_overflow", overflow_err, 0);
      chk("t2_tvalid_held", axis_tvalid, 1);
      chk("t2_credits_stalled", credits - c0, 2 * SF);
      axis_tready = 1'b1;
      drain();
      chk("t2_credits_total", credits - c0, D + 2 * SF);

      // Overflow: extra flit with everything full is dropped.
      axis_tready = 1'b0;
      c0 = credits;
      fill(16'hC000);
      repeat (3) begin @(posedge clk); #1; end
      send(16'hDEAD, 6'h3E, 1'b0);
      chk("t3_overflow_set", overflow_err, 1);
      repeat (5) begin @(posedge clk); #1; end
      chk("t3_overflow_sticky", overflow_err, 1);
      axis_tready = 1'b1;
      drain();
      chk("t3_overflow_after_drain", overflow_err, 1);
      chk("t3_credits_total", credits - c0, D + 2 * SF);

      // Misplaced tail.
      chk("t4_tail_err_clear", tail_err, 0);
      push(64'hE003_E002_E001_E000, 1'b0, 6'h0A);
      send(16'hE000, 6'h0A, 1'b0);
      send(16'hE001, 6'h0A, 1'b1);
      send(16'hE002, 6'h0A, 1'b0);
      send(16'hE003, 6'h0A, 1'b0);
      push(64'hE007_E006_E005_E004, 1'b1, 6'h0B);
      send(16'hE004, 6'h0B, 1'b0);
      send(16'hE005, 6'h0B, 1'b1);
      send(16'hE006, 6'h0B, 1'b0);
      send(16'hE007, 6'h0B, 1'b1);
      drain();
      chk("t4_tail_err_set", tail_err, 1);

      // Reset mid-beat.
      send(16'hF000, 6'h01, 1'b0);
      send(16'hF001, 6'h01, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_tvalid", axis_tvalid, 0);
      chk("t5_tdata", axis_tdata, 0);
      chk("t5_credit", credit_out, 0);
      chk("t5_overflow", overflow_err, 0);
      chk("t5_tail_err", tail_err, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t5_no_credit", credit_out, 0);
      end
      q.delete();
      credits = 0;
      push(64'h4443_4442_4441_4440, 1'b1, 6'h3F);
      send(16'h4440, 6'h3F, 1'b0);
      send(16'h4441, 6'h3F, 1'b0);
      send(16'h4442, 6'h3F, 1'b0);
      send(16'h4443, 6'h3F, 1'b1);
      drain();
      chk("t5_credits", credits, 4);

      // SF=1 continuous stream.
      s0 = cyc;
      for (int i = 0; i < 8; i++) begin
         data1 = 8'(8'h50 + i);
         q1.push_back(8'(8'h50 + i));
         send1 = 1'b1;
         @(posedge clk); #1;
      end
      send1 = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("t6_beats", v1_cnt, 8);
      chk("t6_first_beat_cycle", v1_first, s0 + 2);
      chk("t6_beats_contiguous", v1_last - v1_first, 7);
      chk("t6_credits", c1_cnt, 8);
      chk("t6_credits_contiguous", c1_last - c1_first, 7);
      chk("t6_queue_empty", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
